// File: rtl/audio_sample_fifo_pkg.sv
// Shared types and constants for the audio sample FIFO and its consumers.
package audio_pkg;

  localparam int AUDIO_DATA_SIZE = 16;
  localparam int DROP_CNT_W      = 16;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = {DROP_CNT_W{1'b1}};

  typedef logic [AUDIO_DATA_SIZE-1:0] audio_sample_t;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] cnt);
    return (cnt == DROP_CNT_MAX) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/audio_sample_fifo_if.sv
// Capture strobe, show-ahead pop port and status of the audio sample FIFO.
interface audio_sample_fifo_if
  import audio_pkg::*;
#(
  parameter int DATA_SIZE = AUDIO_DATA_SIZE,
  parameter int DEPTH     = 64
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [DATA_SIZE-1:0]  audio_data;
  logic                  ready;
  logic                  rd_en;
  logic                  overflow_clr;
  logic [DATA_SIZE-1:0]  rd_data;
  logic                  rd_valid;
  logic [LW-1:0]         level;
  logic                  almost_full;
  logic                  overflow;
  logic [DROP_CNT_W-1:0] dropped_count;

  modport master (
    output audio_data, ready, rd_en, overflow_clr,
    input  rd_data, rd_valid, level, almost_full, overflow, dropped_count
  );

  modport slave (
    input  audio_data, ready, rd_en, overflow_clr,
    output rd_data, rd_valid, level, almost_full, overflow, dropped_count
  );

endinterface

// File: rtl/audio_fifo_ram.sv
// Simple dual-port sample store: synchronous write, asynchronous read.
module audio_fifo_ram #(
  parameter  int DATA_SIZE = 16,
  parameter  int DEPTH     = 64,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic [DATA_SIZE-1:0] rdata
);

  logic [DATA_SIZE-1:0] mem_q [DEPTH];

  // NOTE: storage has no reset; empty is decided by the pointers, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/audio_sample_fifo.sv
// Show-ahead FIFO behind receiver_i2s with level, almost-full and drop-newest overflow tracking.
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter int DATA_SIZE   = AUDIO_DATA_SIZE,
  parameter int DEPTH       = 64,
  parameter int AFULL_LEVEL = 48
) (
  input  logic                clk,
  input  logic                rst,
  audio_sample_fifo_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_LEVEL);

  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [PW-1:0]         level_q, level_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic                  empty, full, push, pop, drop;
  logic [DATA_SIZE-1:0]  ram_rdata;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop   = bus.rd_en & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the sample.
  assign push  = bus.ready & (~full | pop);
  assign drop  = bus.ready & full & ~pop;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    wptr_d     = wptr_q + PW'(push);
    rptr_d     = rptr_q + PW'(pop);
    level_d    = wptr_d - rptr_d;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      drop_cnt_d = bus.overflow_clr ? DROP_CNT_W'(1) : sat_inc(drop_cnt_q);
    end else if (bus.overflow_clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  audio_fifo_ram #(
    .DATA_SIZE (DATA_SIZE),
    .DEPTH     (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wptr_q[AW-1:0]),
    .wdata (bus.audio_data),
    .raddr (rptr_q[AW-1:0]),
    .rdata (ram_rdata)
  );

  assign bus.rd_data       = empty ? '0 : ram_rdata;
  assign bus.rd_valid      = ~empty;
  assign bus.level         = level_q;
  assign bus.almost_full   = (level_q >= AFULL_LVL);
  assign bus.overflow      = overflow_q;
  assign bus.dropped_count = drop_cnt_q;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Directed self-checking bench for audio_sample_fifo (DEPTH=64, AFULL_LEVEL=48).
module tb_audio_sample_fifo;
  import audio_pkg::*;

  localparam int DEPTH = 64;
  localparam int AFULL = 48;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  audio_sample_fifo_if #(.DATA_SIZE(AUDIO_DATA_SIZE), .DEPTH(DEPTH)) bus ();

  audio_sample_fifo #(
    .DATA_SIZE   (AUDIO_DATA_SIZE),
    .DEPTH       (DEPTH),
    .AFULL_LEVEL (AFULL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 1 time unit past it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ready        = 1'b0;
    bus.rd_en        = 1'b0;
    bus.overflow_clr = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"},    32'(bus.level),         32'd0);
    check({tag, "_valid"},    32'(bus.rd_valid),      32'd0);
    check({tag, "_data"},     32'(bus.rd_data),       32'd0);
    check({tag, "_afull"},    32'(bus.almost_full),   32'd0);
    check({tag, "_overflow"}, 32'(bus.overflow),      32'd0);
    check({tag, "_dropped"},  32'(bus.dropped_count), 32'd0);
  endtask

  initial begin
    audio_sample_t exp_val;

    idle();
    bus.audio_data = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_all_zero("reset");

    // Basic fill/drain
    bus.ready = 1'b1;
    bus.audio_data = 16'h1234; step();
    check("fill1_level", 32'(bus.level), 32'd1);
    check("fill1_valid", 32'(bus.rd_valid), 32'd1);
    check("fill1_data",  32'(bus.rd_data), 32'h1234);
    bus.audio_data = 16'hABCD; step();
    check("fill2_level", 32'(bus.level), 32'd2);
    bus.audio_data = 16'h0F0F; step();
    check("fill3_level", 32'(bus.level), 32'd3);
    check("fill3_head",  32'(bus.rd_data), 32'h1234);
    idle();
    bus.rd_en = 1'b1;
    step();
    check("drain1_level", 32'(bus.level), 32'd2);
    check("drain1_data",  32'(bus.rd_data), 32'hABCD);
    step();
    check("drain2_level", 32'(bus.level), 32'd1);
    check("drain2_data",  32'(bus.rd_data), 32'h0F0F);
    step();
    check("drain3_level", 32'(bus.level), 32'd0);
    check("drain3_valid", 32'(bus.rd_valid), 32'd0);
    check("drain3_data",  32'(bus.rd_data), 32'd0);

    // Empty corner: pop alone ignored, then pop+push behaves as push
    step();
    check("empty_pop_level", 32'(bus.level), 32'd0);
    check("empty_pop_valid", 32'(bus.rd_valid), 32'd0);
    bus.ready = 1'b1;
    bus.audio_data = 16'h00FF;
    step();
    check("empty_pp_level", 32'(bus.level), 32'd1);
    check("empty_pp_data",  32'(bus.rd_data), 32'h00FF);
    bus.ready = 1'b0;
    step();
    check("empty_pp_drain", 32'(bus.level), 32'd0);
    idle();

    // Fill past full: 66 strobes, last two dropped
    bus.ready = 1'b1;
    for (int i = 0; i < 66; i++) begin
      bus.audio_data = 16'(i);
      step();
      if (i == 46) check("af_below", 32'(bus.almost_full), 32'd0);
      if (i == 47) begin
        check("af_at48_level", 32'(bus.level), 32'd48);
        check("af_at48",       32'(bus.almost_full), 32'd1);
      end
      if (i == 63) begin
        check("full_level",   32'(bus.level), 32'd64);
        check("full_no_ovf",  32'(bus.overflow), 32'd0);
      end
    end
    check("ovf_level",   32'(bus.level), 32'd64);
    check("ovf_flag",    32'(bus.overflow), 32'd1);
    check("ovf_dropped", 32'(bus.dropped_count), 32'd2);
    check("ovf_head",    32'(bus.rd_data), 32'd0);

    // Full with simultaneous push and pop: accepted, no new drop
    bus.audio_data = 16'h5555;
    bus.rd_en = 1'b1;
    step();
    check("fullpp_level",   32'(bus.level), 32'd64);
    check("fullpp_dropped", 32'(bus.dropped_count), 32'd2);
    check("fullpp_head",    32'(bus.rd_data), 32'd1);
    bus.rd_en = 1'b0;

    // Clear vs drop: drop wins, then clear alone
    bus.audio_data = 16'hDEAD;
    bus.overflow_clr = 1'b1;
    step();
    check("clrdrop_ovf",     32'(bus.overflow), 32'd1);
    check("clrdrop_dropped", 32'(bus.dropped_count), 32'd1);
    bus.ready = 1'b0;
    step();
    check("clr_ovf",     32'(bus.overflow), 32'd0);
    check("clr_dropped", 32'(bus.dropped_count), 32'd0);
    idle();

    // Drain: 1..63 then the sample pushed while full
    bus.rd_en = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      exp_val = (k == DEPTH - 1) ? 16'h5555 : 16'(k + 1);
      check("drain_data", 32'(bus.rd_data), 32'(exp_val));
      step();
      check("drain_level", 32'(bus.level), 32'(DEPTH - 1 - k));
      check("drain_afull", 32'(bus.almost_full), 32'((DEPTH - 1 - k) >= AFULL));
    end
    check("drained_valid", 32'(bus.rd_valid), 32'd0);
    idle();

    // Reset mid-stream with a push pending: reset wins
    bus.ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.audio_data = 16'(16'h0100 + i);
      step();
    end
    check("mid_level", 32'(bus.level), 32'd10);
    bus.audio_data = 16'hCAFE;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.ready = 1'b0;
    check_all_zero("midrst");
    bus.ready = 1'b1;
    bus.audio_data = 16'hBEEF;
    step();
    idle();
    check("post_rst_level", 32'(bus.level), 32'd1);
    check("post_rst_data",  32'(bus.rd_data), 32'hBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
